gate_pipe: RTL and testbench
============================

# gate_pipe

Parametrised, pipelined two-operand bitwise logic unit: W-bit operands, run-time selectable operation, DEPTH registered stages, valid/ready flow control on both sides. It generalises the single-bit registered gate cell used in the equivalence-check sample designs into a stallable datapath element. It also provides an optional stuck-lane monitor that flags output bits which have never changed, as a constant-folding hint for the equivalence flow.

## Interface
Parameters:
- W, 8, operand/result width in bits; legal range ≥1.
- DEPTH, 2, number of pipeline stages; legal range ≥1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input transaction offered.
- in_ready  out  1  input transaction accepted this cycle when in_valid && in_ready.
- a  in  W  operand A.
- b  in  W  operand B.
- op  in  2  operation: 0 AND, 1 OR, 2 XOR, 3 ANDN (a & ~b).
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- x  out  W  result.
- xr  out  1  OR-reduction of x, carried in the same stage as x.
- const_mask  out  W  stuck-lane flags (see Configuration).

## Operation
- The pipeline has DEPTH stages. Each stage k holds {vld_k, data_k[W], red_k}.
- Stage 0 loads f(a, b, op) and its OR-reduction on input accept. op is sampled together with a/b and never affects a transaction already in flight.
- Advance rule: stage k loads from stage k-1 when stage k is empty or stage k is unloading this cycle. The last stage unloads on out_valid && out_ready.
- in_ready = !vld_0 || stage 0 unloading this cycle. This is combinational from out_ready through the stage chain; no registered skid.
- A stage that loads nothing while unloading clears its vld.
- out_valid = vld_{DEPTH-1}, x = data_{DEPTH-1}, xr = red_{DEPTH-1}.
- While out_valid && !out_ready: x, xr and out_valid hold stable. Upstream stages keep filling empty slots (bubble collapse).
- When all stages are full and out_ready is low, in_ready is 0 and no transaction is dropped or duplicated.
- Ordering is strictly FIFO. Capacity is DEPTH transactions.

## Timing
- Reset (asynchronous assert; deassert synchronous to clk by the system): all vld=0, all data=0, x=0, xr=0, out_valid=0, in_ready=1, const_mask all ones.
- Reset mid-operation discards every in-flight transaction immediately.
- Latency: an accept at edge n presents out_valid at edge n+DEPTH-1 (visible after that edge), provided out_ready was high throughout. With DEPTH=1 the result is visible the cycle after accept.
- Throughput: one transaction per cycle while out_ready is held high.
- Simultaneous accept and unload on a full pipeline is legal and sustains full rate.
- Stall effect: out_ready low for S cycles adds S cycles of latency to every transaction queued behind the stalled one.

## Configuration
- GATE_PIPE_CONST_CHK_EN defined: the stuck-lane monitor is compiled in.
  - The first output handshake after reset stores x into ref[W]; const_mask stays all ones.
  - Each later handshake clears const_mask[i] wherever x[i] != ref[i]. Bits are sticky-cleared until reset.
  - const_mask changes only on output handshakes and is registered: it updates on the same edge as the handshake.
- GATE_PIPE_CONST_CHK_EN undefined: the monitor logic is absent and const_mask is tied to all zeros.
- The datapath is identical in both builds.

## Test plan
- W=8, DEPTH=2, out_ready=1: a=0xF0, b=0x3C through op 0..3 on consecutive cycles → x=0x30, 0xFC, 0xCC, 0xC0 on 4 consecutive cycles, each 2 cycles after its accept; xr=1 for every result.
- a=0x00, b=0xFF, op=0 → x=0x00, xr=0.
- a=0xAA, b=0x00, op=1 → x=0xAA, xr=1. This mirrors the constant-tied-input AND/OR identities.
- Backpressure: drive 5 transactions with out_ready=0. Check in_ready drops after exactly 2 accepts. Raise out_ready: results emerge in order with no loss or duplicates, and x stays stable throughout the stall.
- Reset mid-stream: assert rst_n=0 with 2 transactions in flight → out_valid=0, x=0 immediately. After release, the first new transaction is unaffected by pre-reset data.
- With GATE_PIPE_CONST_CHK_EN: outputs 0x0F, 0x0F, 0x1F, 0x8F → const_mask 0xFF, 0xFF, 0xEF, 0x6F after each handshake. Without the macro, const_mask reads 0x00.
- DEPTH=1, W=1 (single-cell equivalent): a=1, b=1, op=0 → x=1 one cycle after accept. Toggling out_ready every cycle yields one result per two cycles with no loss.

Source files
------------

// File: rtl/gate_pipe_if.sv
// gate_pipe_if: handshake and data bundle for gate_pipe.
// master = producer/consumer side (drives operands and out_ready),
// slave  = the gate_pipe datapath itself.
interface gate_pipe_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] x;
  logic         xr;
  logic [W-1:0] const_mask;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, x, xr, const_mask
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, x, xr, const_mask
  );
endinterface

// File: rtl/gate_pipe.sv
// gate_pipe: stallable DEPTH-stage pipelined two-operand bitwise unit
// (op 0 AND, 1 OR, 2 XOR, 3 ANDN) with valid/ready on both sides.
// Each stage advances when it is empty or its content is leaving, so
// bubbles collapse while the output is stalled; in_ready is combinational
// from out_ready through the stage chain.
// Optional feature macro: GATE_PIPE_CONST_CHK_EN compiles in the stuck-lane
// monitor (const_mask); without it const_mask is tied to zero.
module gate_pipe #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  gate_pipe_if.slave   bus
);

  typedef logic [W-1:0] word_t;

  word_t f_res;
  logic  in_ready_int;
  logic  out_valid_int;
  word_t x_int;

  // Operation select; op travels with its operands, so only stage 0 sees it.
  always_comb begin
    case (bus.op)
      2'd0:    f_res = bus.a & bus.b;
      2'd1:    f_res = bus.a | bus.b;
      2'd2:    f_res = bus.a ^ bus.b;
      default: f_res = bus.a & ~bus.b;
    endcase
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : stg
    logic  vld_q, vld_d;
    logic  red_q, red_d;
    word_t data_q, data_d;
    logic  load, unload, src_red;
    word_t src_data;

    if (gi == 0) begin : g_head
      assign load     = bus.in_valid && in_ready_int;
      assign src_data = f_res;
      assign src_red  = |f_res;
    end else begin : g_body
      assign load     = stg[gi-1].unload;
      assign src_data = stg[gi-1].data_q;
      assign src_red  = stg[gi-1].red_q;
    end

    if (gi == DEPTH-1) begin : g_tail
      assign unload = vld_q && bus.out_ready;
    end else begin : g_mid
      // Content moves on when the next slot is free or is itself emptying.
      assign unload = vld_q && (!stg[gi+1].vld_q || stg[gi+1].unload);
    end

    // Next-state: load takes priority; an unload with nothing behind it empties the slot.
    always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      red_d  = red_q;
      if (load) begin
        vld_d  = 1'b1;
        data_d = src_data;
        red_d  = src_red;
      end else if (unload) begin
        vld_d  = 1'b0;
      end
    end

    // Stage registers; reset discards any in-flight transaction at once.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        data_q <= '0;
        red_q  <= 1'b0;
      end else begin
        vld_q  <= vld_d;
        data_q <= data_d;
        red_q  <= red_d;
      end
    end
  end

  assign in_ready_int  = !stg[0].vld_q || stg[0].unload;
  assign out_valid_int = stg[DEPTH-1].vld_q;
  assign x_int         = stg[DEPTH-1].data_q;

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.x         = x_int;
  assign bus.xr        = stg[DEPTH-1].red_q;

`ifdef GATE_PIPE_CONST_CHK_EN
  logic  seen_q, seen_d;
  word_t ref_val_q, ref_val_d;
  word_t mask_q, mask_d;
  logic  out_hs;

  assign out_hs = out_valid_int && bus.out_ready;

  // First output after reset becomes the reference; later outputs clear differing lanes.
  always_comb begin
    seen_d    = seen_q;
    ref_val_d = ref_val_q;
    mask_d    = mask_q;
    if (out_hs) begin
      if (!seen_q) begin
        seen_d    = 1'b1;
        ref_val_d = x_int;
      end else begin
        mask_d = mask_q & ~(x_int ^ ref_val_q);
      end
    end
  end

  // Monitor registers; mask bits stay cleared until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q    <= 1'b0;
      ref_val_q <= '0;
      mask_q    <= '1;
    end else begin
      seen_q    <= seen_d;
      ref_val_q <= ref_val_d;
      mask_q    <= mask_d;
    end
  end

  assign bus.const_mask = mask_q;
`else
  assign bus.const_mask = '0;
`endif

endmodule

// File: tb/tb_gate_pipe.sv
// tb_gate_pipe: self-checking bench for gate_pipe (W=8/DEPTH=2 and W=1/DEPTH=1).
// The reference model is a pair of queues: every accepted transaction pushes
// its expected result, every output handshake pushes what was observed.
module tb_gate_pipe;

  localparam int DEPTH8 = 2;
`ifdef GATE_PIPE_CONST_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [7:0] x;
    logic       xr;
    int         cyc;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gate_pipe_if #(.W(8)) bus8 ();
  gate_pipe_if #(.W(1)) bus1 ();

  gate_pipe #(.W(8), .DEPTH(2)) u8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  gate_pipe #(.W(1), .DEPTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  rec_t exp8[$], obs8[$], exp1[$], obs1[$];
  bit         mdl_seen;
  logic [7:0] mdl_first, mdl_diff;

  function automatic logic [7:0] gate_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return a & ~b;
    endcase
  endfunction

  function automatic logic [7:0] model_mask();
    if (!CHK) return 8'h00;
    if (!mdl_seen) return 8'hFF;
    return ~mdl_diff;
  endfunction

  // One clock: record handshakes into the model queues, then advance past the edge.
  task automatic tick();
    rec_t r;
    logic [7:0] t;
    #2;
    if (rst_n) begin
      if (bus8.in_valid && bus8.in_ready) begin
        r.x = gate_f(bus8.op, bus8.a, bus8.b); r.xr = |r.x; r.cyc = cyc;
        exp8.push_back(r);
      end
      if (bus8.out_valid && bus8.out_ready) begin
        r.x = bus8.x; r.xr = bus8.xr; r.cyc = cyc;
        obs8.push_back(r);
        if (!mdl_seen) begin mdl_seen = 1'b1; mdl_first = bus8.x; end
        else mdl_diff = mdl_diff | (bus8.x ^ mdl_first);
      end
      if (bus1.in_valid && bus1.in_ready) begin
        t = gate_f(bus1.op, {7'b0, bus1.a}, {7'b0, bus1.b});
        r.x = {7'b0, t[0]}; r.xr = t[0]; r.cyc = cyc;
        exp1.push_back(r);
      end
      if (bus1.out_valid && bus1.out_ready) begin
        r.x = {7'b0, bus1.x}; r.xr = bus1.xr; r.cyc = cyc;
        obs1.push_back(r);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    bus8.in_valid = 1'b0; bus1.in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    exp8.delete(); obs8.delete(); exp1.delete(); obs1.delete();
    mdl_seen = 1'b0; mdl_first = '0; mdl_diff = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus8.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus8.out_valid); end
    checks++; if (bus8.x !== 8'h00) begin failures++; $display("FAIL reset_x got=%h exp=00", bus8.x); end
    checks++; if (bus8.xr !== 1'b0) begin failures++; $display("FAIL reset_xr got=%b exp=0", bus8.xr); end
    checks++; if (bus8.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus8.in_ready); end
    checks++; if (bus8.const_mask !== (CHK ? 8'hFF : 8'h00)) begin failures++; $display("FAIL reset_const_mask got=%h exp=%h", bus8.const_mask, (CHK ? 8'hFF : 8'h00)); end
    checks++; if (bus1.out_valid !== 1'b0 || bus1.x !== 1'b0 || bus1.in_ready !== 1'b1) begin failures++; $display("FAIL reset_w1 got=v%b x%b r%b exp=v0 x0 r1", bus1.out_valid, bus1.x, bus1.in_ready); end
    do_reset();
  endtask

  task automatic test_directed();
    logic [7:0] ta[6], tbv[6], ex[6];
    logic [1:0] top[6];
    logic       exr[6];
    int n;
    ta  = '{8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'h00, 8'hAA};
    tbv = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'hFF, 8'h00};
    top = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    ex  = '{8'h30, 8'hFC, 8'hCC, 8'hC0, 8'h00, 8'hAA};
    exr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    bus8.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus8.in_valid = 1'b1; bus8.a = ta[i]; bus8.b = tbv[i]; bus8.op = top[i];
      tick();
    end
    bus8.in_valid = 1'b0;
    n = 0;
    while (obs8.size() < 6 && n < 10) begin tick(); n++; end
    checks++; if (exp8.size() != 6 || obs8.size() != 6) begin failures++; $display("FAIL dir_count got=acc%0d out%0d exp=6", exp8.size(), obs8.size()); end
    for (int i = 0; i < 6 && i < obs8.size() && i < exp8.size(); i++) begin
      checks++; if (obs8[i].x !== ex[i]) begin failures++; $display("FAIL dir_x[%0d] got=%h exp=%h", i, obs8[i].x, ex[i]); end
      checks++; if (obs8[i].xr !== exr[i]) begin failures++; $display("FAIL dir_xr[%0d] got=%b exp=%b", i, obs8[i].xr, exr[i]); end
      checks++; if (obs8[i].cyc - exp8[i].cyc != DEPTH8) begin failures++; $display("FAIL dir_latency[%0d] got=%0d exp=%0d", i, obs8[i].cyc - exp8[i].cyc, DEPTH8); end
      checks++; if (obs8[i].cyc != obs8[0].cyc + i) begin failures++; $display("FAIL dir_rate[%0d] got=%0d exp=%0d", i, obs8[i].cyc, obs8[0].cyc + i); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] ta[5], tbv[5];
    logic [1:0] top[5];
    logic [7:0] sx;
    bit have;
    int j, n;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ta[i] = 8'($urandom); tbv[i] = 8'($urandom); top[i] = 2'($urandom);
    end
    bus8.out_ready = 1'b0;
    j = 0; have = 0; sx = '0;
    for (int k = 0; k < 5; k++) begin
      bus8.in_valid = 1'b1; bus8.a = ta[j]; bus8.b = tbv[j]; bus8.op = top[j];
      tick();
      if (exp8.size() > j) j++;
      if (bus8.out_valid) begin
        if (!have) begin have = 1; sx = bus8.x; end
        else begin
          checks++; if (bus8.x !== sx) begin failures++; $display("FAIL bp_stall_x got=%h exp=%h", bus8.x, sx); end
        end
      end
    end
    checks++; if (j != 2) begin failures++; $display("FAIL bp_accepts got=%0d exp=2", j); end
    checks++; if (bus8.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", bus8.in_ready); end
    checks++; if (sx !== gate_f(top[0], ta[0], tbv[0])) begin failures++; $display("FAIL bp_head got=%h exp=%h", sx, gate_f(top[0], ta[0], tbv[0])); end
    bus8.out_ready = 1'b1;
    n = 0;
    while ((obs8.size() < 5 || j < 5) && n < 30) begin
      if (j < 5) begin bus8.in_valid = 1'b1; bus8.a = ta[j]; bus8.b = tbv[j]; bus8.op = top[j]; end
      else bus8.in_valid = 1'b0;
      tick();
      if (exp8.size() > j) j++;
      n++;
    end
    bus8.in_valid = 1'b0;
    checks++; if (obs8.size() != 5) begin failures++; $display("FAIL bp_out_count got=%0d exp=5", obs8.size()); end
    for (int i = 0; i < 5 && i < obs8.size(); i++) begin
      checks++; if (obs8[i].x !== gate_f(top[i], ta[i], tbv[i])) begin failures++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, obs8[i].x, gate_f(top[i], ta[i], tbv[i])); end
    end
  endtask

  task automatic test_random();
    int occ, n;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      bus8.in_valid = 1'($urandom);
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.op = 2'($urandom);
      bus8.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      occ = exp8.size() - obs8.size();
      checks++; if (bus8.in_ready !== ((occ < DEPTH8) || bus8.out_ready)) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b occ=%0d", cyc, bus8.in_ready, ((occ < DEPTH8) || bus8.out_ready), occ); end
      tick();
      checks++; if (exp8.size() - obs8.size() > DEPTH8) begin failures++; $display("FAIL rnd_capacity got=%0d exp<=%0d", exp8.size() - obs8.size(), DEPTH8); end
    end
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
    n = 0;
    while (obs8.size() < exp8.size() && n < 10) begin tick(); n++; end
    checks++; if (obs8.size() != exp8.size()) begin failures++; $display("FAIL rnd_count got=%0d exp=%0d", obs8.size(), exp8.size()); end
    for (int i = 0; i < obs8.size() && i < exp8.size(); i++) begin
      checks++; if (obs8[i].x !== exp8[i].x || obs8[i].xr !== exp8[i].xr) begin failures++; $display("FAIL rnd_data[%0d] got=%h/%b exp=%h/%b", i, obs8[i].x, obs8[i].xr, exp8[i].x, exp8[i].xr); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] na, nb, e;
    logic [1:0] nop;
    int n;
    do_reset();
    bus8.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus8.in_valid = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h5A; bus8.op = 2'd2;
      tick();
    end
    bus8.in_valid = 1'b0;
    checks++; if (bus8.out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", bus8.out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus8.out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b exp=0", bus8.out_valid); end
    checks++; if (bus8.x !== 8'h00) begin failures++; $display("FAIL mid_x got=%h exp=00", bus8.x); end
    checks++; if (bus8.in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%b exp=1", bus8.in_ready); end
    do_reset();
    na = 8'($urandom); nb = 8'($urandom); nop = 2'($urandom);
    e = gate_f(nop, na, nb);
    bus8.out_ready = 1'b1;
    bus8.in_valid = 1'b1; bus8.a = na; bus8.b = nb; bus8.op = nop;
    tick();
    bus8.in_valid = 1'b0;
    n = 0;
    while (obs8.size() < 1 && n < 6) begin tick(); n++; end
    repeat (3) tick();
    checks++; if (obs8.size() != 1) begin failures++; $display("FAIL mid_post_count got=%0d exp=1", obs8.size()); end
    if (obs8.size() > 0) begin
      checks++; if (obs8[0].x !== e || obs8[0].xr !== |e) begin failures++; $display("FAIL mid_post_x got=%h/%b exp=%h/%b", obs8[0].x, obs8[0].xr, e, |e); end
    end
  endtask

  task automatic test_const();
    logic [7:0] vals[4], em[4];
    int n;
    vals = '{8'h0F, 8'h0F, 8'h1F, 8'h8F};
    em   = CHK ? '{8'hFF, 8'hFF, 8'hEF, 8'h6F} : '{8'h00, 8'h00, 8'h00, 8'h00};
    do_reset();
    bus8.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus8.in_valid = 1'b1; bus8.a = vals[i]; bus8.b = 8'h00; bus8.op = 2'd1;
      tick();
      bus8.in_valid = 1'b0;
      n = 0;
      while (obs8.size() < i + 1 && n < 5) begin tick(); n++; end
      checks++; if (bus8.const_mask !== em[i]) begin failures++; $display("FAIL const_mask[%0d] got=%h exp=%h", i, bus8.const_mask, em[i]); end
      checks++; if (bus8.const_mask !== model_mask()) begin failures++; $display("FAIL const_model[%0d] got=%h exp=%h", i, bus8.const_mask, model_mask()); end
    end
  endtask

  task automatic test_single();
    int n, outs;
    do_reset();
    bus1.out_ready = 1'b1;
    bus1.in_valid = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1; bus1.op = 2'd0;
    tick();
    bus1.in_valid = 1'b0;
    checks++; if (bus1.out_valid !== 1'b1 || bus1.x !== 1'b1) begin failures++; $display("FAIL w1_latency got=v%b x%b exp=v1 x1", bus1.out_valid, bus1.x); end
    tick();
    checks++; if (obs1.size() != 1 || exp1.size() != 1) begin failures++; $display("FAIL w1_first got=out%0d acc%0d exp=1", obs1.size(), exp1.size()); end
    for (int k = 0; k < 20; k++) begin
      bus1.in_valid = 1'b1; bus1.a = 1'($urandom); bus1.b = 1'($urandom); bus1.op = 2'($urandom);
      bus1.out_ready = 1'(k % 2);
      tick();
    end
    outs = obs1.size() - 1;
    checks++; if (outs != 10) begin failures++; $display("FAIL w1_toggle_rate got=%0d exp=10", outs); end
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
    n = 0;
    while (obs1.size() < exp1.size() && n < 5) begin tick(); n++; end
    checks++; if (obs1.size() != exp1.size()) begin failures++; $display("FAIL w1_count got=%0d exp=%0d", obs1.size(), exp1.size()); end
    for (int i = 0; i < obs1.size() && i < exp1.size(); i++) begin
      checks++; if (obs1[i].x !== exp1[i].x) begin failures++; $display("FAIL w1_data[%0d] got=%h exp=%h", i, obs1[i].x, exp1[i].x); end
    end
  endtask

  initial begin
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.op = '0; bus8.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.op = '0; bus1.out_ready = 1'b0;
    mdl_seen = 1'b0; mdl_first = '0; mdl_diff = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_const();
    test_single();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
